// File: rtl/spw_link_timer.sv
// SpaceWire link-FSM timer: prescaled after64/after128 timeouts with run-time thresholds.
// Defining SPW_DISC_TIMER_EN adds the disconnect watchdog (rx_activity in, disconnect out).
module spw_link_timer #(
  parameter int CNT_W     = 12,
  parameter int PRESC_W   = 4,
  parameter int PRESC_DIV = 1,
  parameter int T_SHORT   = 1280,
  parameter int T_LONG    = 2560,
  parameter int PERIODIC  = 1
`ifdef SPW_DISC_TIMER_EN
  ,
  parameter int DISC_W    = 8,
  parameter int DISC_CNT  = 85
`endif
) (
  input  logic             CLOCK,
  input  logic             RESETn,
  input  logic             enableTimer,
  input  logic             restart,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_short,
  input  logic [CNT_W-1:0] cfg_long,
`ifdef SPW_DISC_TIMER_EN
  input  logic             rx_activity,
  output logic             disconnect,
`endif
  output logic             after64,
  output logic             after128,
  output logic             expired,
  output logic             cfg_err,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]   T_SHORT_C   = CNT_W'(T_SHORT);
  localparam logic [CNT_W-1:0]   T_LONG_C    = CNT_W'(T_LONG);
  localparam logic [PRESC_W-1:0] PRESC_ZERO  = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE   = PRESC_W'(32'd1);
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(PRESC_DIV - 32'sd1);
  localparam bit                 ONE_SHOT    = (PERIODIC == 32'sd0);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   thr_short_q, thr_short_d;
  logic [CNT_W-1:0]   thr_long_q, thr_long_d;
  logic               a64_q, a64_d;
  logic               a128_q, a128_d;
  logic               expired_q, expired_d;
  logic               cfg_err_q, cfg_err_d;

  // Next-state: priority is disable > restart > one-shot hold > tick processing.
  always_comb begin
    cnt_d       = cnt_q;
    presc_d     = presc_q;
    thr_short_d = thr_short_q;
    thr_long_d  = thr_long_q;
    a64_d       = 1'b0;
    a128_d      = 1'b0;
    expired_d   = expired_q;
    cfg_err_d   = cfg_err_q;
    if (!enableTimer) begin
      cnt_d     = CNT_ZERO;
      presc_d   = PRESC_ZERO;
      expired_d = 1'b0;
      if (cfg_load) begin
        if (cfg_short < cfg_long) begin
          thr_short_d = cfg_short;
          thr_long_d  = cfg_long;
          cfg_err_d   = 1'b0;
        end else begin
          cfg_err_d   = 1'b1;
        end
      end else begin
        cfg_err_d = cfg_err_q;
      end
    end else if (restart) begin
      cnt_d     = CNT_ZERO;
      presc_d   = PRESC_ZERO;
      expired_d = 1'b0;
    end else if (ONE_SHOT && expired_q) begin
      // One-shot run is finished: freeze the count and emit nothing more.
      cnt_d = cnt_q;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = PRESC_ZERO;
      if (cnt_q == thr_long_q) begin
        a128_d    = 1'b1;
        expired_d = 1'b1;
        cnt_d     = ONE_SHOT ? cnt_q : CNT_ZERO;
      end else if (cnt_q == thr_short_q) begin
        a64_d = 1'b1;
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // Timer state registers with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      cnt_q       <= CNT_ZERO;
      presc_q     <= PRESC_ZERO;
      thr_short_q <= T_SHORT_C;
      thr_long_q  <= T_LONG_C;
      a64_q       <= 1'b0;
      a128_q      <= 1'b0;
      expired_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      thr_short_q <= thr_short_d;
      thr_long_q  <= thr_long_d;
      a64_q       <= a64_d;
      a128_q      <= a128_d;
      expired_q   <= expired_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign after64  = a64_q;
  assign after128 = a128_q;
  assign expired  = expired_q;
  assign cfg_err  = cfg_err_q;
  assign count    = cnt_q;

`ifdef SPW_DISC_TIMER_EN
  localparam logic [DISC_W-1:0] DISC_ZERO = {DISC_W{1'b0}};
  localparam logic [DISC_W-1:0] DISC_ONE  = DISC_W'(32'd1);
  localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(DISC_CNT);

  logic [DISC_W-1:0] disc_cnt_q, disc_cnt_d;
  logic              disc_q, disc_d;

  // Disconnect watchdog: unprescaled, any clear source beats reaching the limit.
  always_comb begin
    disc_cnt_d = disc_cnt_q;
    disc_d     = disc_q;
    if (!enableTimer || restart || rx_activity) begin
      disc_cnt_d = DISC_ZERO;
      disc_d     = 1'b0;
    end else if (disc_cnt_q == DISC_LAST) begin
      disc_cnt_d = disc_cnt_q;
      disc_d     = 1'b1;
    end else begin
      disc_cnt_d = disc_cnt_q + DISC_ONE;
      disc_d     = ((disc_cnt_q + DISC_ONE) == DISC_LAST);
    end
  end

  // Disconnect watchdog registers.
  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      disc_cnt_q <= DISC_ZERO;
      disc_q     <= 1'b0;
    end else begin
      disc_cnt_q <= disc_cnt_d;
      disc_q     <= disc_d;
    end
  end

  assign disconnect = disc_q;
`endif

endmodule

// File: tb/tb_spw_link_timer.sv
// Directed bench for spw_link_timer: default legacy timing, prescaled and one-shot
// variants, configuration loading, reset/disable priority and the optional watchdog.
module tb_spw_link_timer;

  logic        clk = 1'b0;
  logic        rst_n, en, rst_cnt, cfg_load, rx_act;
  logic [11:0] cfg_short, cfg_long;

  logic        a64_a, a128_a, exp_a, err_a, disc_a;
  logic        a64_b, a128_b, exp_b, err_b, disc_b;
  logic        a64_c, a128_c, exp_c, err_c, disc_c;
  logic [11:0] cnt_a, cnt_b, cnt_c;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spw_link_timer dut_a (
    .CLOCK(clk), .RESETn(rst_n), .enableTimer(en), .restart(rst_cnt),
    .cfg_load(cfg_load), .cfg_short(cfg_short), .cfg_long(cfg_long),
`ifdef SPW_DISC_TIMER_EN
    .rx_activity(rx_act), .disconnect(disc_a),
`endif
    .after64(a64_a), .after128(a128_a), .expired(exp_a), .cfg_err(err_a), .count(cnt_a)
  );

  spw_link_timer #(.PRESC_DIV(4)) dut_b (
    .CLOCK(clk), .RESETn(rst_n), .enableTimer(en), .restart(rst_cnt),
    .cfg_load(cfg_load), .cfg_short(cfg_short), .cfg_long(cfg_long),
`ifdef SPW_DISC_TIMER_EN
    .rx_activity(rx_act), .disconnect(disc_b),
`endif
    .after64(a64_b), .after128(a128_b), .expired(exp_b), .cfg_err(err_b), .count(cnt_b)
  );

  spw_link_timer #(.PERIODIC(0)) dut_c (
    .CLOCK(clk), .RESETn(rst_n), .enableTimer(en), .restart(rst_cnt),
    .cfg_load(cfg_load), .cfg_short(cfg_short), .cfg_long(cfg_long),
`ifdef SPW_DISC_TIMER_EN
    .rx_activity(rx_act), .disconnect(disc_c),
`endif
    .after64(a64_c), .after128(a128_c), .expired(exp_c), .cfg_err(err_c), .count(cnt_c)
  );

  typedef struct {
    int   edge_n;
    logic a64;
    logic a128;
    logic expd;
    int   cnt;
  } chk_pt_t;

  typedef struct {
    logic        en;
    logic        load;
    logic [11:0] sh;
    logic [11:0] lg;
    logic        err;
  } cfg_vec_t;

  chk_pt_t  cp [9];
  cfg_vec_t cv [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n64, n128;

    cp[0] = '{1280, 1'b0, 1'b0, 1'b0, 1280};
    cp[1] = '{1281, 1'b1, 1'b0, 1'b0, 1281};
    cp[2] = '{1282, 1'b0, 1'b0, 1'b0, 1282};
    cp[3] = '{2560, 1'b0, 1'b0, 1'b0, 2560};
    cp[4] = '{2561, 1'b0, 1'b1, 1'b1, 0};
    cp[5] = '{2562, 1'b0, 1'b0, 1'b1, 1};
    cp[6] = '{3842, 1'b1, 1'b0, 1'b1, 1281};
    cp[7] = '{5122, 1'b0, 1'b1, 1'b1, 0};
    cp[8] = '{6000, 1'b0, 1'b0, 1'b1, 878};

    cv[0] = '{1'b0, 1'b1, 12'd10, 12'd10, 1'b1};
    cv[1] = '{1'b0, 1'b1, 12'd0,  12'd0,  1'b1};
    cv[2] = '{1'b1, 1'b1, 12'd2,  12'd5,  1'b1};
    cv[3] = '{1'b0, 1'b0, 12'd2,  12'd5,  1'b1};
    cv[4] = '{1'b0, 1'b1, 12'd2,  12'd5,  1'b0};
    cv[5] = '{1'b0, 1'b1, 12'd7,  12'd3,  1'b1};
    cv[6] = '{1'b0, 1'b1, 12'd2,  12'd5,  1'b0};
    cv[7] = '{1'b1, 1'b1, 12'd9,  12'd9,  1'b0};

    rst_n = 1'b0; en = 1'b0; rst_cnt = 1'b0; cfg_load = 1'b0; rx_act = 1'b0;
    cfg_short = 12'd0; cfg_long = 12'd0;
    run_edges(3);
    chk("reset_count", 32'(cnt_a), 32'd0);
    chk("reset_after64", 32'(a64_a), 32'd0);
    chk("reset_after128", 32'(a128_a), 32'd0);
    chk("reset_expired", 32'(exp_a), 32'd0);
    chk("reset_cfg_err", 32'(err_a), 32'd0);
    chk("reset_count_b", 32'(cnt_b), 32'd0);

    // Legacy timing with default thresholds and PRESC_DIV=1.
    rst_n = 1'b1; en = 1'b1;
    n64 = 0; n128 = 0;
    for (int e = 1; e <= 6000; e++) begin
      step();
      if (a64_a) n64++;
      if (a128_a) n128++;
      for (int i = 0; i < 9; i++) begin
        if (cp[i].edge_n == e) begin
          chk($sformatf("legacy_a64_E%0d", e), 32'(a64_a), 32'(cp[i].a64));
          chk($sformatf("legacy_a128_E%0d", e), 32'(a128_a), 32'(cp[i].a128));
          chk($sformatf("legacy_expired_E%0d", e), 32'(exp_a), 32'(cp[i].expd));
          chk($sformatf("legacy_count_E%0d", e), 32'(cnt_a), cp[i].cnt);
        end
      end
    end
    chk("legacy_a64_cycles", n64, 2);
    chk("legacy_a128_cycles", n128, 2);

    en = 1'b0;
    step();
    chk("disable_count", 32'(cnt_a), 32'd0);
    chk("disable_expired", 32'(exp_a), 32'd0);
    chk("disable_cfg_err", 32'(err_a), 32'd0);

    // Configuration load accept/reject/ignore table.
    for (int i = 0; i < 8; i++) begin
      en = cv[i].en; cfg_load = cv[i].load; cfg_short = cv[i].sh; cfg_long = cv[i].lg;
      step();
      chk($sformatf("cfg_err_vec%0d", i), 32'(err_a), 32'(cv[i].err));
    end
    cfg_load = 1'b0; en = 1'b0;
    step();
    en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk($sformatf("thr25_a64_E%0d", e), 32'(a64_a), 32'((e == 3) || (e == 9)));
      chk($sformatf("thr25_a128_E%0d", e), 32'(a128_a), 32'((e == 6) || (e == 12)));
      chk($sformatf("thr25_count_E%0d", e), 32'(cnt_a), e % 6);
    end

    // Thresholds 3/6: prescaled periodic (dut_b) and one-shot (dut_c).
    en = 1'b0; cfg_load = 1'b1; cfg_short = 12'd3; cfg_long = 12'd6;
    step();
    cfg_load = 1'b0; en = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      chk($sformatf("presc_a64_E%0d", e), 32'(a64_b), 32'(e == 16));
      chk($sformatf("presc_a128_E%0d", e), 32'(a128_b), 32'(e == 28));
      chk($sformatf("presc_count_E%0d", e), 32'(cnt_b), (e / 4) % 7);
      chk($sformatf("oneshot_a64_E%0d", e), 32'(a64_c), 32'(e == 4));
      chk($sformatf("oneshot_a128_E%0d", e), 32'(a128_c), 32'(e == 7));
      chk($sformatf("oneshot_count_E%0d", e), 32'(cnt_c), (e < 7) ? e : 6);
      chk($sformatf("oneshot_expired_E%0d", e), 32'(exp_c), 32'(e >= 7));
    end
    rst_cnt = 1'b1;
    step();
    chk("restart_count", 32'(cnt_c), 32'd0);
    chk("restart_expired", 32'(exp_c), 32'd0);
    rst_cnt = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("rerun_a64_E%0d", e), 32'(a64_c), 32'(e == 4));
      chk($sformatf("rerun_count_E%0d", e), 32'(cnt_c), e);
    end
    // Restart coincides with the long timeout edge and must win.
    rst_cnt = 1'b1;
    step();
    chk("restart_vs_timeout_a128", 32'(a128_c), 32'd0);
    chk("restart_vs_timeout_count", 32'(cnt_c), 32'd0);
    chk("restart_vs_timeout_expired", 32'(exp_c), 32'd0);
    rst_cnt = 1'b0;

    // Rejected load leaves cfg_err set so reset can be seen clearing it.
    en = 1'b0; cfg_load = 1'b1; cfg_short = 12'd5; cfg_long = 12'd5;
    step();
    chk("reject_55_cfg_err", 32'(err_a), 32'd1);
    cfg_load = 1'b0; en = 1'b1;
    run_edges(3);
    rst_n = 1'b0;
    step();
    chk("reset2_cfg_err", 32'(err_a), 32'd0);
    chk("reset2_count", 32'(cnt_a), 32'd0);

    // Reset restores default thresholds; reset and disable beat tick processing.
    rst_n = 1'b1;
    n64 = 0;
    for (int e = 1; e <= 1000; e++) begin
      step();
      if (a64_a) n64++;
    end
    chk("restored_thr_count1000", 32'(cnt_a), 32'd1000);
    chk("restored_thr_no_a64", n64, 0);
    rst_n = 1'b0;
    step();
    chk("midreset_count", 32'(cnt_a), 32'd0);
    chk("midreset_after64", 32'(a64_a), 32'd0);
    chk("midreset_expired", 32'(exp_a), 32'd0);
    rst_n = 1'b1;
    run_edges(1280);
    chk("pre_drop_count", 32'(cnt_a), 32'd1280);
    en = 1'b0;
    step();
    chk("drop_count", 32'(cnt_a), 32'd0);
    chk("drop_after64", 32'(a64_a), 32'd0);
    en = 1'b1;
    run_edges(1281);
    chk("kept_thr_after64_E1281", 32'(a64_a), 32'd1);
    chk("kept_thr_count_E1281", 32'(cnt_a), 32'd1281);

`ifdef SPW_DISC_TIMER_EN
    en = 1'b0; rx_act = 1'b0;
    step();
    en = 1'b1;
    for (int e = 1; e <= 90; e++) begin
      step();
      chk($sformatf("disc_idle_E%0d", e), 32'(disc_a), 32'(e >= 85));
    end
    rx_act = 1'b1;
    step();
    chk("disc_cleared_by_activity", 32'(disc_a), 32'd0);
    rx_act = 1'b0;
    en = 1'b0;
    step();
    en = 1'b1;
    run_edges(84);
    chk("disc_E84", 32'(disc_a), 32'd0);
    rx_act = 1'b1;
    step();
    chk("disc_activity_at_E85", 32'(disc_a), 32'd0);
    rx_act = 1'b0;
    step();
    chk("disc_after_activity_E86", 32'(disc_a), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
